// File: rtl/sram_port_arbiter.sv
// Shares port 0 of the sram_32_16_sky130 macro between a Wishbone slave and a
// valid/ready stream requester, with round-robin grants and byte-lane RMW writes.
module sram_port_arbiter #(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [DW/8-1:0] wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [DW-1:0]   wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [DW-1:0]   wbs_dat_o,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [AW-1:0]   req_addr_i,
  input  logic [DW-1:0]   req_wdata_i,
  output logic            rsp_valid_o,
  output logic [DW-1:0]   rsp_rdata_o,
  output logic            sram_csb0_o,
  output logic            sram_web0_o,
  output logic [AW-1:0]   sram_addr0_o,
  output logic [DW-1:0]   sram_din0_o,
  input  logic [DW-1:0]   sram_dout0_i
);

  typedef enum logic [2:0] {IDLE, RD_CMD, RD_CAP, WR_CMD, DONE} state_t;

  state_t          state;
  logic            last_wb;
  logic            own_wb;
  logic            op_rmw;
  logic [DW/8-1:0] sel_q;
  logic            wb_pend;
  logic            st_pend;
  logic            grant_wb;
  logic            grant_st;
  logic [AW-1:0]   wb_addr;
  logic            unused_adr_bits;

  function automatic logic [DW-1:0] merge_lanes(input logic [DW-1:0]   old_w,
                                                input logic [DW-1:0]   new_w,
                                                input logic [DW/8-1:0] sel);
    logic [DW-1:0] m;
    m = old_w;
    for (int i = 0; i < DW/8; i++)
      if (sel[i]) m[8*i +: 8] = new_w[8*i +: 8];
    return m;
  endfunction

  assign wb_addr         = wbs_adr_i[AW+1:2];
  assign unused_adr_bits = ^{wbs_adr_i[31:AW+2], wbs_adr_i[1:0]};

  // Round-robin: on a tie the side that did not win last time gets the port.
  assign wb_pend  = (state == IDLE) && wbs_cyc_i && wbs_stb_i;
  assign st_pend  = (state == IDLE) && req_valid_i;
  assign grant_wb = wb_pend && (!st_pend || !last_wb);
  assign grant_st = st_pend && (!wb_pend || last_wb);

  // Gated by reset so the stream never sees a handshake while the block is held.
  assign req_ready_o = wb_rst_ni && grant_st;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state        <= IDLE;
      last_wb      <= 1'b0;
      own_wb       <= 1'b0;
      op_rmw       <= 1'b0;
      sel_q        <= '0;
      wbs_ack_o    <= 1'b0;
      wbs_dat_o    <= '0;
      rsp_valid_o  <= 1'b0;
      rsp_rdata_o  <= '0;
      sram_csb0_o  <= 1'b1;
      sram_web0_o  <= 1'b1;
      sram_addr0_o <= '0;
      sram_din0_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_wb) begin
            own_wb       <= 1'b1;
            last_wb      <= 1'b1;
            sel_q        <= wbs_sel_i;
            sram_addr0_o <= wb_addr;
            sram_din0_o  <= wbs_dat_i;
            op_rmw       <= 1'b0;
            if (!wbs_we_i) begin
              sram_csb0_o <= 1'b0;
              sram_web0_o <= 1'b1;
              state       <= RD_CMD;
            end else if (wbs_sel_i == '1) begin
              sram_csb0_o <= 1'b0;
              sram_web0_o <= 1'b0;
              state       <= WR_CMD;
            end else if (wbs_sel_i == '0) begin
              wbs_ack_o <= 1'b1;
              state     <= DONE;
            end else begin
              // Partial write: fetch the old word first, merge in RD_CAP.
              op_rmw      <= 1'b1;
              sram_csb0_o <= 1'b0;
              sram_web0_o <= 1'b1;
              state       <= RD_CMD;
            end
          end else if (grant_st) begin
            own_wb       <= 1'b0;
            last_wb      <= 1'b0;
            op_rmw       <= 1'b0;
            sram_addr0_o <= req_addr_i;
            sram_din0_o  <= req_wdata_i;
            sram_csb0_o  <= 1'b0;
            sram_web0_o  <= ~req_we_i;
            state        <= req_we_i ? WR_CMD : RD_CMD;
          end
        end
        RD_CMD: begin
          sram_csb0_o <= 1'b1;
          sram_web0_o <= 1'b1;
          state       <= RD_CAP;
        end
        RD_CAP: begin
          if (op_rmw) begin
            sram_din0_o <= merge_lanes(sram_dout0_i, sram_din0_o, sel_q);
            sram_csb0_o <= 1'b0;
            sram_web0_o <= 1'b0;
            state       <= WR_CMD;
          end else begin
            state <= DONE;
            if (own_wb) begin
              wbs_dat_o <= sram_dout0_i;
              wbs_ack_o <= wbs_cyc_i;
            end else begin
              rsp_rdata_o <= sram_dout0_i;
              rsp_valid_o <= 1'b1;
            end
          end
        end
        WR_CMD: begin
          sram_csb0_o <= 1'b1;
          sram_web0_o <= 1'b1;
          if (own_wb) wbs_ack_o <= wbs_cyc_i;
          state <= DONE;
        end
        DONE: begin
          wbs_ack_o   <= 1'b0;
          rsp_valid_o <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural SRAM and a response
// scoreboard keyed by owner (0 = Wishbone, 1 = stream).
module tb_sram_port_arbiter;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_ni = 1'b1;
  logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        req_valid_i = 1'b0, req_we_i = 1'b0;
  logic [3:0]  req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        req_ready_o, rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        sram_csb0_o, sram_web0_o;
  logic [3:0]  sram_addr0_o;
  logic [31:0] sram_din0_o, sram_dout0_i;

  typedef struct packed {logic owner; logic [31:0] data;} exp_t;
  exp_t sb_q[$];

  int pass_cnt = 0, fail_cnt = 0, total_cnt = 0;
  int csb_low_cnt = 0, rsp_cnt = 0;

  logic [31:0] mem [16];

  sram_port_arbiter #(.AW(4), .DW(32)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .sram_csb0_o(sram_csb0_o), .sram_web0_o(sram_web0_o),
    .sram_addr0_o(sram_addr0_o), .sram_din0_o(sram_din0_o),
    .sram_dout0_i(sram_dout0_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // SRAM port 0: command sampled at the edge, read data visible the next cycle.
  always @(posedge wb_clk_i) begin
    if (!sram_csb0_o) begin
      if (!sram_web0_o) mem[sram_addr0_o] <= sram_din0_o;
      else              sram_dout0_i      <= mem[sram_addr0_o];
    end
  end

  always @(negedge wb_clk_i) begin
    if (!sram_csb0_o) csb_low_cnt <= csb_low_cnt + 1;
    if (rsp_valid_o)  rsp_cnt     <= rsp_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag, input logic obs_owner);
    exp_t e;
    if (sb_q.size() == 0) begin
      total_cnt++;
      fail_cnt++;
      $error("FAIL %s: unexpected response, scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_owner"}, {31'b0, obs_owner}, {31'b0, e.owner});
      check({tag, "_data"}, obs_owner ? rsp_rdata_o : wbs_dat_o, e.data);
    end
  endtask

  // Counts cycles from the grant cycle (cycle 0) to the response pulse.
  task automatic wait_evt(input logic is_wb, output int lat);
    lat = -1;
    for (int c = 1; c <= 8; c++) begin
      tick;
      if (c == 1) req_valid_i = 1'b0;
      if (is_wb ? wbs_ack_o : rsp_valid_o) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic wb_op(input string tag, input logic we, input logic [31:0] adr,
                       input logic [3:0] sel, input logic [31:0] dat,
                       input int exp_lat, input logic [31:0] exp_rd);
    int lat;
    if (!we) sb_q.push_back('{owner: 1'b0, data: exp_rd});
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_sel_i = sel; wbs_adr_i = adr; wbs_dat_i = dat;
    wait_evt(1'b1, lat);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    check({tag, "_lat"}, lat, exp_lat);
    if (!we) pop_check(tag, 1'b0);
    tick;
  endtask

  task automatic st_write(input string tag, input logic [3:0] addr, input logic [31:0] dat);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = addr; req_wdata_i = dat;
    #1 check({tag, "_ready"}, req_ready_o, 1);
    tick;
    req_valid_i = 1'b0;
    check({tag, "_c1_csb"}, sram_csb0_o, 0);
    check({tag, "_c1_web"}, sram_web0_o, 0);
    check({tag, "_c1_addr"}, sram_addr0_o, addr);
    check({tag, "_c1_din"}, sram_din0_o, dat);
    tick;
    check({tag, "_no_rsp"}, rsp_valid_o, 0);
    tick;
  endtask

  task automatic st_read(input string tag, input logic [3:0] addr, input logic [31:0] exp_rd);
    int lat;
    sb_q.push_back('{owner: 1'b1, data: exp_rd});
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = addr;
    #1 check({tag, "_ready"}, req_ready_o, 1);
    wait_evt(1'b0, lat);
    check({tag, "_lat"}, lat, 3);
    pop_check(tag, 1'b1);
    tick;
  endtask

  initial begin
    int lat, n, snap;

    // Reset with both requesters active: nothing may be granted.
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; req_valid_i = 1'b1;
    #1 wb_rst_ni = 1'b0;
    tick; tick; tick;
    check("rst_ready", req_ready_o, 0);
    check("rst_csb", sram_csb0_o, 1);
    check("rst_web", sram_web0_o, 1);
    check("rst_addr", sram_addr0_o, 0);
    check("rst_din", sram_din0_o, 0);
    check("rst_ack", wbs_ack_o, 0);
    check("rst_wbdat", wbs_dat_o, 0);
    check("rst_rspv", rsp_valid_o, 0);
    check("rst_rdata", rsp_rdata_o, 0);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; req_valid_i = 1'b0;
    wb_rst_ni = 1'b1;
    tick;

    st_write("st_wr3", 4'd3, 32'hDEADBEEF);
    st_read("st_rd3", 4'd3, 32'hDEADBEEF);

    wb_op("wb_full", 1'b1, 32'h14, 4'hF, 32'h11223344, 2, 32'h0);
    wb_op("wb_part", 1'b1, 32'h14, 4'b0101, 32'hAABBCCDD, 4, 32'h0);
    wb_op("wb_rd5", 1'b0, 32'h14, 4'hF, 32'h0, 3, 32'h11BB33DD);
    wb_op("wb_wrap", 1'b0, 32'hABCD_0054, 4'hF, 32'h0, 3, 32'h11BB33DD);

    st_write("st_wr7", 4'd7, 32'h55AA55AA);
    snap = csb_low_cnt;
    wb_op("wb_sel0", 1'b1, 32'h1C, 4'h0, 32'h0, 1, 32'h0);
    check("sel0_csb_quiet", csb_low_cnt - snap, 0);
    st_read("st_rd7", 4'd7, 32'h55AA55AA);

    // Wishbone read abandoned in cycle 2, stream queued behind it.
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_sel_i = 4'hF; wbs_adr_i = 32'h0C;
    tick;
    tick;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    tick;
    check("abort_ack", wbs_ack_o, 0);
    check("abort_dat", wbs_dat_o, 32'hDEADBEEF);
    sb_q.push_back('{owner: 1'b1, data: 32'h55AA55AA});
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 4'd7;
    #1 check("abort_busy_ready", req_ready_o, 0);
    tick;
    check("abort_next_ready", req_ready_o, 1);
    wait_evt(1'b0, lat);
    check("abort_st_lat", lat, 3);
    pop_check("abort_st", 1'b1);
    tick;

    // Fresh reset, then both requesters held pending for 8 operations.
    wb_rst_ni = 1'b0;
    tick; tick;
    wb_rst_ni = 1'b1;
    tick;
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back('{owner: 1'b0, data: 32'hDEADBEEF});
      sb_q.push_back('{owner: 1'b1, data: 32'h55AA55AA});
    end
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_sel_i = 4'hF; wbs_adr_i = 32'h0C;
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 4'd7;
    #1 check("arb_first_ready", req_ready_o, 0);
    n = 0;
    for (int c = 0; c < 64 && n < 8; c++) begin
      tick;
      if (wbs_ack_o) begin
        pop_check("arb_wb", 1'b0);
        n++;
      end
      if (rsp_valid_o) begin
        pop_check("arb_st", 1'b1);
        n++;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; req_valid_i = 1'b0;
    check("arb_ops", n, 8);
    tick; tick;

    // Reset pulse landing in RD_CAP of a stream read.
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 4'd3;
    tick;
    req_valid_i = 1'b0;
    tick;
    #2 wb_rst_ni = 1'b0;
    #1;
    check("midrst_csb", sram_csb0_o, 1);
    check("midrst_web", sram_web0_o, 1);
    check("midrst_addr", sram_addr0_o, 0);
    check("midrst_din", sram_din0_o, 0);
    check("midrst_wbdat", wbs_dat_o, 0);
    check("midrst_rdata", rsp_rdata_o, 0);
    check("midrst_rspv", rsp_valid_o, 0);
    snap = rsp_cnt;
    tick; tick;
    wb_rst_ni = 1'b1;
    tick; tick;
    check("midrst_no_rsp", rsp_cnt - snap, 0);
    st_read("post_rst_rd3", 4'd3, 32'hDEADBEEF);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
